sprite_command_scheduler: RTL and testbench

//  Queues CPU sprite commands {sprite id, instruction, data} and replays them to the per-sprite

---
 rtl/sprite_pkg.sv | 25 ++
 rtl/sprite_cmd_fifo.sv | 56 +++++
 rtl/sprite_command_scheduler.sv | 127 ++++++++++++
 tb/tb_sprite_command_scheduler.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite command scheduler: instruction codes, bus widths
// and the scheduler state type.
package sprite_pkg;

  localparam int INSTR_W = 4;
  localparam int DATA_W  = 23;

  localparam logic [INSTR_W-1:0] SPR_NOP        = 4'd0;
  localparam logic [INSTR_W-1:0] SPR_SET_SPRITE = 4'd1;
  localparam logic [INSTR_W-1:0] SPR_SET_X      = 4'd2;
  localparam logic [INSTR_W-1:0] SPR_SET_Y      = 4'd3;
  localparam logic [INSTR_W-1:0] SPR_SET_W      = 4'd4;
  localparam logic [INSTR_W-1:0] SPR_SET_H      = 4'd5;
  localparam logic [INSTR_W-1:0] SPR_SHIFT_X    = 4'd6;
  localparam logic [INSTR_W-1:0] SPR_SHIFT_Y    = 4'd7;
  localparam logic [INSTR_W-1:0] SPR_HIDE       = 4'd8;
  localparam logic [INSTR_W-1:0] SPR_SHOW       = 4'd9;
  localparam logic [INSTR_W-1:0] SPR_FRAME_END  = 4'd15;

  typedef enum logic {
    ST_IDLE,
    ST_DRAIN
  } state_e;

endpackage

// File: rtl/sprite_cmd_fifo.sv
// Synchronous command FIFO with occupancy count; read data is the head entry
// (show-ahead), so a pop consumes the word presented on o_data.
module sprite_cmd_fifo #(
  parameter int WIDTH = 30,
  parameter int DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_level == LW'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  // NOTE: storage has no reset; occupancy is tracked by the pointers and level,
  // so stale contents are never observable and the array maps to plain RAM.
  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push_ok && !w_pop_ok)      r_level <= r_level + 1'b1;
      else if (!w_push_ok && w_pop_ok) r_level <= r_level - 1'b1;
    end
  end

endmodule

// File: rtl/sprite_command_scheduler.sv
// Buffers CPU sprite commands and replays them to the sprite controller bank only
// during vertical blanking; a FRAME_END entry ends the current batch.
module sprite_command_scheduler
  import sprite_pkg::*;
#(
  parameter int NUM_SPRITES = 8,
  parameter int SPRITE_ID_W = 3,
  parameter int DEPTH       = 16
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_cmd_valid,
  output logic                     o_cmd_ready,
  input  logic [SPRITE_ID_W-1:0]   i_cmd_sprite,
  input  logic [INSTR_W-1:0]       i_cmd_instruction,
  input  logic [DATA_W-1:0]        i_cmd_data,
  input  logic                     i_vblank,
  output logic [NUM_SPRITES-1:0]   o_sprite_write,
  output logic [INSTR_W-1:0]       o_sprite_instruction,
  output logic [DATA_W-1:0]        o_sprite_data,
  output logic                     o_busy,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_drop_error
);

  localparam int ENTRY_W = SPRITE_ID_W + INSTR_W + DATA_W;

  state_e                  r_state;
  state_e                  w_state_next;
  logic                    r_vblank_d;
  logic [NUM_SPRITES-1:0]  r_sprite_write;
  logic [INSTR_W-1:0]      r_sprite_instruction;
  logic [DATA_W-1:0]       r_sprite_data;
  logic                    r_drop_error;

  logic                    w_full;
  logic                    w_empty;
  logic                    w_push;
  logic                    w_pop;
  logic [ENTRY_W-1:0]      w_head;
  logic [SPRITE_ID_W-1:0]  w_pop_id;
  logic [INSTR_W-1:0]      w_pop_instr;
  logic [DATA_W-1:0]       w_pop_data;
  logic                    w_id_ok;
  logic                    w_sprite_op;
  logic                    w_reserved_op;
  logic                    w_strobe;
  logic                    w_drop;
  logic [NUM_SPRITES-1:0]  w_onehot;

  assign o_cmd_ready = !w_full;
  assign w_push      = i_cmd_valid && o_cmd_ready;
  assign w_pop       = (r_state == ST_DRAIN) && i_vblank && !w_empty;

  sprite_cmd_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (w_push),
    .i_data  ({i_cmd_sprite, i_cmd_instruction, i_cmd_data}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_level (o_level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign {w_pop_id, w_pop_instr, w_pop_data} = w_head;

  // NOP and FRAME_END are control entries and never depend on the sprite id.
  assign w_id_ok       = (32'(w_pop_id) < NUM_SPRITES);
  assign w_sprite_op   = (w_pop_instr >= SPR_SET_SPRITE) && (w_pop_instr <= SPR_SHOW);
  assign w_reserved_op = (w_pop_instr > SPR_SHOW) && (w_pop_instr < SPR_FRAME_END);
  assign w_strobe      = w_pop && w_sprite_op && w_id_ok;
  assign w_drop        = w_pop && (w_reserved_op || (w_sprite_op && !w_id_ok));
  assign w_onehot      = {{(NUM_SPRITES-1){1'b0}}, 1'b1} << w_pop_id;

  // NOTE: the next state is defaulted before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (i_vblank && !r_vblank_d) w_state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!i_vblank) w_state_next = ST_IDLE;
        else if (w_pop && (w_pop_instr == SPR_FRAME_END)) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_state_next;
  end

  // The VBlank history resets high so a blank already in progress at reset
  // release is not mistaken for a rising edge.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_vblank_d           <= 1'b1;
      r_sprite_write       <= '0;
      r_sprite_instruction <= '0;
      r_sprite_data        <= '0;
      r_drop_error         <= 1'b0;
    end else begin
      r_vblank_d     <= i_vblank;
      r_sprite_write <= w_strobe ? w_onehot : '0;
      if (w_strobe) begin
        r_sprite_instruction <= w_pop_instr;
        r_sprite_data        <= w_pop_data;
      end
      if (w_drop) r_drop_error <= 1'b1;
    end
  end

  assign o_sprite_write       = r_sprite_write;
  assign o_sprite_instruction = r_sprite_instruction;
  assign o_sprite_data        = r_sprite_data;
  assign o_drop_error         = r_drop_error;
  assign o_busy               = (r_state == ST_DRAIN);

endmodule

// File: tb/tb_sprite_command_scheduler.sv
// Directed self-checking bench for sprite_command_scheduler: batching on VBlank,
// FRAME_END splits, full FIFO, drop errors, and reset in the middle of a drain.
module tb_sprite_command_scheduler;
  import sprite_pkg::*;

  localparam int NUM_SPRITES = 8;
  localparam int SPRITE_ID_W = 4;
  localparam int DEPTH       = 16;

  logic                     clk;
  logic                     reset;
  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [SPRITE_ID_W-1:0]   cmd_sprite;
  logic [INSTR_W-1:0]       cmd_instruction;
  logic [DATA_W-1:0]        cmd_data;
  logic                     vblank;
  logic [NUM_SPRITES-1:0]   sprite_write;
  logic [INSTR_W-1:0]       sprite_instruction;
  logic [DATA_W-1:0]        sprite_data;
  logic                     busy;
  logic [$clog2(DEPTH):0]   level;
  logic                     drop_error;

  int n_checks   = 0;
  int n_failures = 0;

  sprite_command_scheduler #(
    .NUM_SPRITES (NUM_SPRITES),
    .SPRITE_ID_W (SPRITE_ID_W),
    .DEPTH       (DEPTH)
  ) dut (
    .i_clk                (clk),
    .i_reset              (reset),
    .i_cmd_valid          (cmd_valid),
    .o_cmd_ready          (cmd_ready),
    .i_cmd_sprite         (cmd_sprite),
    .i_cmd_instruction    (cmd_instruction),
    .i_cmd_data           (cmd_data),
    .i_vblank             (vblank),
    .o_sprite_write       (sprite_write),
    .o_sprite_instruction (sprite_instruction),
    .o_sprite_data        (sprite_data),
    .o_busy               (busy),
    .o_level              (level),
    .o_drop_error         (drop_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic push(input int id, input logic [INSTR_W-1:0] ins, input int data);
    cmd_valid       = 1'b1;
    cmd_sprite      = SPRITE_ID_W'(id);
    cmd_instruction = ins;
    cmd_data        = DATA_W'(data);
    step();
    cmd_valid       = 1'b0;
  endtask

  int                     strobes;
  logic [NUM_SPRITES-1:0] first_write;
  logic [NUM_SPRITES-1:0] any_write;

  initial begin
    reset = 1'b1; vblank = 1'b0; cmd_valid = 1'b0;
    cmd_sprite = '0; cmd_instruction = '0; cmd_data = '0;
    step(); step(); step();
    check("rst_write", 64'(sprite_write), 64'h0);
    check("rst_instr", 64'(sprite_instruction), 64'h0);
    check("rst_data",  64'(sprite_data), 64'h0);
    check("rst_busy",  64'(busy), 64'h0);
    check("rst_level", 64'(level), 64'h0);
    check("rst_drop",  64'(drop_error), 64'h0);
    reset = 1'b0;
    step();
    check("rst_ready", 64'(cmd_ready), 64'h1);

    // 1: three commands held until the blank, then back-to-back strobes
    push(2, SPR_SET_X, 100);
    push(2, SPR_SET_Y, 40);
    push(5, SPR_SHOW, 0);
    check("t1_level", 64'(level), 64'd3);
    check("t1_nostrobe", 64'(sprite_write), 64'h0);
    vblank = 1'b1;
    step();
    check("t1_busy", 64'(busy), 64'h1);
    check("t1_edge_nostrobe", 64'(sprite_write), 64'h0);
    step();
    check("t1_w0", 64'(sprite_write), 64'h04);
    check("t1_i0", 64'(sprite_instruction), 64'(SPR_SET_X));
    check("t1_d0", 64'(sprite_data), 64'd100);
    step();
    check("t1_w1", 64'(sprite_write), 64'h04);
    check("t1_i1", 64'(sprite_instruction), 64'(SPR_SET_Y));
    check("t1_d1", 64'(sprite_data), 64'd40);
    step();
    check("t1_w2", 64'(sprite_write), 64'h20);
    check("t1_i2", 64'(sprite_instruction), 64'(SPR_SHOW));
    check("t1_d2", 64'(sprite_data), 64'd0);
    step();
    check("t1_w_idle", 64'(sprite_write), 64'h0);
    check("t1_i_hold", 64'(sprite_instruction), 64'(SPR_SHOW));
    check("t1_level0", 64'(level), 64'd0);
    check("t1_busy_empty", 64'(busy), 64'h1);
    vblank = 1'b0;
    step();
    check("t1_busy_off", 64'(busy), 64'h0);

    // 2: FRAME_END splits the queue across two blanks
    push(1, SPR_SET_X, 11);
    push(3, SPR_SET_Y, 22);
    push(4, SPR_SET_W, 33);
    push(0, SPR_FRAME_END, 0);
    push(6, SPR_HIDE, 44);
    push(7, SPR_SET_H, 55);
    check("t2_level6", 64'(level), 64'd6);
    vblank = 1'b1;
    strobes = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (sprite_write != '0) strobes++;
    end
    check("t2_strobes_a", 64'(strobes), 64'd3);
    check("t2_level2", 64'(level), 64'd2);
    check("t2_busy_after_fe", 64'(busy), 64'h0);
    check("t2_last_data_a", 64'(sprite_data), 64'd33);
    vblank = 1'b0;
    step();
    vblank = 1'b1;
    strobes = 0;
    first_write = '0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (sprite_write != '0) begin
        if (strobes == 0) first_write = sprite_write;
        strobes++;
      end
    end
    check("t2_strobes_b", 64'(strobes), 64'd2);
    check("t2_first_b", 64'(first_write), 64'h40);
    check("t2_last_instr_b", 64'(sprite_instruction), 64'(SPR_SET_H));
    check("t2_last_data_b", 64'(sprite_data), 64'd55);
    check("t2_level0", 64'(level), 64'd0);
    vblank = 1'b0;
    step();

    // 3: full FIFO refuses a 17th command; one pop reopens it
    for (int k = 0; k < DEPTH; k++) push(k % NUM_SPRITES, SPR_SET_X, k);
    check("t3_level_full", 64'(level), 64'd16);
    check("t3_ready_full", 64'(cmd_ready), 64'h0);
    push(3, SPR_SET_Y, 999);
    check("t3_level_17th", 64'(level), 64'd16);
    vblank = 1'b1;
    step();
    check("t3_ready_edge", 64'(cmd_ready), 64'h0);
    step();
    check("t3_ready_after_pop", 64'(cmd_ready), 64'h1);
    check("t3_level15", 64'(level), 64'd15);
    check("t3_w0", 64'(sprite_write), 64'h01);
    check("t3_d0", 64'(sprite_data), 64'd0);
    vblank = 1'b0;
    step();
    check("t3_no_pop_on_fall", 64'(level), 64'd15);
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    check("t3_level_after_rst", 64'(level), 64'd0);

    // 4: out-of-range id and reserved instruction are dropped
    push(9, SPR_SET_X, 1);
    push(1, 4'd12, 0);
    vblank = 1'b1;
    any_write = '0;
    for (int i = 0; i < 6; i++) begin
      step();
      any_write = any_write | sprite_write;
    end
    check("t4_no_strobes", 64'(any_write), 64'h0);
    check("t4_drop", 64'(drop_error), 64'h1);
    check("t4_level0", 64'(level), 64'd0);
    vblank = 1'b0;
    step(); step(); step();
    check("t4_drop_sticky", 64'(drop_error), 64'h1);

    // 5: VBlank falling mid-batch, then reset mid-drain
    push(0, SPR_SET_X, 1);
    push(1, SPR_SET_Y, 2);
    push(2, SPR_SET_W, 3);
    push(3, SPR_SET_H, 4);
    push(4, SPR_SHIFT_X, 5);
    push(5, SPR_SHIFT_Y, 6);
    vblank = 1'b1;
    step();
    step();
    check("t5_w0", 64'(sprite_write), 64'h01);
    step();
    check("t5_w1", 64'(sprite_write), 64'h02);
    check("t5_d1", 64'(sprite_data), 64'd2);
    vblank = 1'b0;
    step();
    check("t5_w_stop", 64'(sprite_write), 64'h0);
    check("t5_level4", 64'(level), 64'd4);
    check("t5_busy_off", 64'(busy), 64'h0);
    vblank = 1'b1;
    step();
    step();
    check("t5_w2", 64'(sprite_write), 64'h04);
    reset = 1'b1;
    step();
    check("t5_rst_write", 64'(sprite_write), 64'h0);
    check("t5_rst_instr", 64'(sprite_instruction), 64'h0);
    check("t5_rst_data", 64'(sprite_data), 64'h0);
    check("t5_rst_busy", 64'(busy), 64'h0);
    check("t5_rst_level", 64'(level), 64'd0);
    check("t5_rst_drop", 64'(drop_error), 64'h0);

    // 6: reset released inside a blank is not an edge
    reset = 1'b0;
    step();
    check("t6_ready", 64'(cmd_ready), 64'h1);
    push(6, SPR_SHOW, 77);
    any_write = '0;
    for (int i = 0; i < 5; i++) begin
      step();
      any_write = any_write | sprite_write;
    end
    check("t6_no_strobe", 64'(any_write), 64'h0);
    check("t6_busy", 64'(busy), 64'h0);
    check("t6_level1", 64'(level), 64'd1);
    vblank = 1'b0;
    step();
    vblank = 1'b1;
    step();
    check("t6_busy_edge", 64'(busy), 64'h1);
    step();
    check("t6_w", 64'(sprite_write), 64'h40);
    check("t6_i", 64'(sprite_instruction), 64'(SPR_SHOW));
    check("t6_d", 64'(sprite_data), 64'd77);
    check("t6_level0", 64'(level), 64'd0);
    vblank = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
    $finish;
  end

endmodule
